fir_driver: RTL and testbench
=============================

FIR_DRIVER -- requirements
Module: fir_driver

Interface
REQ-001 SHALL have parameters pADDR_WIDTH (default 12, AXI-Lite address width), pDATA_WIDTH (default 32, data width) and Tape_Num (default 11, coefficient count written to the FIR).
REQ-002 SHALL have ports (name, direction, width, meaning):
- axis_clk, in, 1: the single clock.
- axis_rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: run request pulse.
- len, in, pDATA_WIDTH: sample count, latched on an accepted start.
- busy, out, 1: run in progress.
- done, out, 1: run finished.
- err, out, 1: run error.
- coef_idx, out, 4: coefficient index.
- coef_data, in, pDATA_WIDTH: coefficient value, combinational from coef_idx.
- src_tvalid/src_tdata/src_tready, in/in/out, 1/pDATA_WIDTH/1: upstream samples.
- dst_tvalid/dst_tdata/dst_tlast/dst_tready, out/out/out/in, 1/pDATA_WIDTH/1/1: downstream results.
- awvalid/awaddr/awready, out/out/in, 1/pADDR_WIDTH/1: AXI-Lite write address.
- wvalid/wdata/wready, out/out/in, 1/pDATA_WIDTH/1: AXI-Lite write data.
- arvalid/araddr/arready, out/out/in, 1/pADDR_WIDTH/1: AXI-Lite read address.
- rvalid/rdata/rready, in/in/out, 1/pDATA_WIDTH/1: AXI-Lite read data.
- ss_tvalid/ss_tdata/ss_tlast/ss_tready, out/out/out/in, 1/pDATA_WIDTH/1/1: x[n] stream to the FIR.
- sm_tvalid/sm_tdata/sm_tlast/sm_tready, in/in/in/out, 1/pDATA_WIDTH/1/1: y[n] stream from the FIR.

Function
REQ-003 SHALL implement FSM states IDLE, TAP_WR, LEN_WR, TNUM_WR, START_WR, STREAM, POLL_RD and DONE.
REQ-004 IDLE: start=1 SHALL latch len and clear done and err. If len=0 it SHALL go to DONE with err=1 and issue no transactions; otherwise it SHALL go to TAP_WR. Start SHALL be ignored outside IDLE and DONE.
REQ-005 Each AXI-Lite write SHALL assert awvalid and wvalid together and hold each until its own ready is sampled high. The write SHALL complete when both handshakes have occurred, in either order or the same cycle. Address and data SHALL stay stable while their valid is high.
REQ-006 TAP_WR SHALL issue Tape_Num writes: address 0x80+4*i, data coef_data, with coef_idx=i for i=0..Tape_Num-1, strictly in order, one outstanding at a time.
REQ-007 The block SHALL then write, in sequence: LEN_WR: 0x10 <= len; TNUM_WR: 0x14 <= Tape_Num; START_WR: 0x00 <= 1. It SHALL then enter STREAM.
REQ-008 STREAM, send side: a 1-entry holding register SHALL drive ss_*. src_tready SHALL be 1 when the register is empty or draining (ss_tvalid&ss_tready) and sent count < len. ss_tlast SHALL be 1 on sample len-1.
REQ-009 STREAM, receive side: a 1-entry output register SHALL drive dst_*. sm_tready SHALL be 1 when the register is empty or dst_tready=1. dst_tlast SHALL be 1 on result len-1. A full register with dst_tready=0 SHALL backpressure the FIR without loss.
REQ-010 sm_tlast SHALL be checked against received count = len-1; any mismatch, including an early tlast, SHALL set err.
REQ-011 STREAM SHALL exit when len samples have been sent, len results received and the output register has drained.
REQ-012 Sent and received counters SHALL be pDATA_WIDTH wide; the block SHALL not wrap within one run.
REQ-013 busy SHALL be 1 in every state except IDLE and DONE. DONE SHALL assert done=1 and hold it until the next accepted start. DONE SHALL accept start exactly as IDLE does.

Reset
REQ-014 axis_rst_n=0 SHALL asynchronously force IDLE, with all valids, readies, busy, done, err and coef_idx at 0, all data/address outputs at 0, and both holding registers and counters cleared.
REQ-015 Reset asserted mid-transaction SHALL abort it with no completion; after reset release, the block SHALL stay in IDLE until a new start.

Configuration
REQ-016 With macro FIR_DRIVER_POLL_EN defined, STREAM SHALL exit to POLL_RD. POLL_RD SHALL read address 0x00 (arvalid held until arready; rready=1 until rvalid) repeatedly, back-to-back, until rdata[1]=1, then go to DONE.
REQ-017 Without FIR_DRIVER_POLL_EN, STREAM SHALL go directly to DONE, arvalid and rready SHALL be tied 0, and no read logic SHALL exist.

Verification
REQ-018 Scenario: taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, len=3, src 1,2,3 -> write order 0x80..0xA8, then 0x10=3, 0x14=11, 0x00=1; dst 0,-10,-29 with tlast on -29; done=1, err=0.
REQ-019 Scenario: FIR awready 2 cycles before wready, then the same cycle on the next write -> exactly one write per address, no duplicates, all 14 writes complete.
REQ-020 Scenario: dst_tready=0 for 20 cycles mid-stream, len=8 -> sm_tready drops, no result lost or reordered, 8 results delivered.
REQ-021 Scenario: len=0 -> done=1 and err=1 within 2 cycles; awvalid and ss_tvalid never asserted.
REQ-022 Scenario: FIR asserts sm_tlast on result 2 of len=5 -> err=1.
REQ-023 Scenario: axis_rst_n pulsed during the tap write at i=5 -> all outputs 0 immediately; a new start re-runs from i=0. With POLL_EN: done asserts only after a read returns rdata=0x6.

Source files
------------

// File: rtl/fir_driver.sv
// fir_driver: programs a FIR core over AXI-Lite (taps, length, tap count, start),
// then streams len samples src -> FIR (ss_*) and len results FIR (sm_*) -> dst.
// Optional macro FIR_DRIVER_POLL_EN: after streaming, poll status register 0x00
// until bit 1 (done) reads back set before reporting done.
module fir_driver #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pDATA_WIDTH-1:0] len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [3:0]             coef_idx,
    input  logic [pDATA_WIDTH-1:0] coef_data,
    input  logic                   src_tvalid,
    input  logic [pDATA_WIDTH-1:0] src_tdata,
    output logic                   src_tready,
    output logic                   dst_tvalid,
    output logic [pDATA_WIDTH-1:0] dst_tdata,
    output logic                   dst_tlast,
    input  logic                   dst_tready,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready
);

    typedef enum logic [2:0] {
        StIdle, StTapWr, StLenWr, StTnumWr, StStartWr, StStream, StPollRd, StDone
    } state_e;

    state_e                 state_q;
    logic [pDATA_WIDTH-1:0] len_q;
    logic [pDATA_WIDTH-1:0] sent_cnt_q;
    logic [pDATA_WIDTH-1:0] recv_cnt_q;
    logic                   wr_issued_q;
    logic                   aw_done_q;
    logic                   w_done_q;

    logic                   wr_fire;
    logic                   src_fire;
    logic                   ss_fire;
    logic                   sm_fire;
    logic                   dst_fire;
    logic                   last_sent;
    logic                   last_recv;
    logic                   stream_end;
    logic [pADDR_WIDTH-1:0] wr_addr;
    logic [pDATA_WIDTH-1:0] wr_data;

    assign busy = (state_q != StIdle) && (state_q != StDone);

    // A write completes once both channels have handshaked, in any order
    assign wr_fire = wr_issued_q && (aw_done_q || (awvalid && awready))
                                 && (w_done_q  || (wvalid  && wready));

    assign ss_fire    = ss_tvalid && ss_tready;
    assign src_tready = (state_q == StStream) && (!ss_tvalid || ss_fire) && (sent_cnt_q < len_q);
    assign src_fire   = src_tvalid && src_tready;
    assign dst_fire   = dst_tvalid && dst_tready;
    assign sm_tready  = (state_q == StStream) && (!dst_tvalid || dst_tready);
    assign sm_fire    = sm_tvalid && sm_tready;
    assign last_sent  = (sent_cnt_q == len_q - pDATA_WIDTH'(1));
    assign last_recv  = (recv_cnt_q == len_q - pDATA_WIDTH'(1));
    assign stream_end = (sent_cnt_q == len_q) && (recv_cnt_q == len_q) && !ss_tvalid && !dst_tvalid;

    assign araddr = '0;

`ifdef FIR_DRIVER_POLL_EN
    logic unused_rdata;
    assign unused_rdata = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};
`else
    assign arvalid = 1'b0;
    assign rready  = 1'b0;
    logic unused_rd;
    assign unused_rd = ^{arready, rvalid, rdata};
`endif

    // Address/data of the register write owned by the current state
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            StTapWr: begin
                wr_addr = pADDR_WIDTH'(8'h80) + pADDR_WIDTH'({coef_idx, 2'b00});
                wr_data = coef_data;
            end
            StLenWr: begin
                wr_addr = pADDR_WIDTH'(8'h10);
                wr_data = len_q;
            end
            StTnumWr: begin
                wr_addr = pADDR_WIDTH'(8'h14);
                wr_data = pDATA_WIDTH'(Tape_Num);
            end
            StStartWr: begin
                wr_addr = '0;
                wr_data = pDATA_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // Sequencer: FSM, AXI-Lite channels, stream holding registers and counters
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            sent_cnt_q  <= '0;
            recv_cnt_q  <= '0;
            wr_issued_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            coef_idx    <= '0;
            awvalid     <= 1'b0;
            awaddr      <= '0;
            wvalid      <= 1'b0;
            wdata       <= '0;
            ss_tvalid   <= 1'b0;
            ss_tdata    <= '0;
            ss_tlast    <= 1'b0;
            dst_tvalid  <= 1'b0;
            dst_tdata   <= '0;
            dst_tlast   <= 1'b0;
`ifdef FIR_DRIVER_POLL_EN
            arvalid     <= 1'b0;
            rready      <= 1'b0;
`endif
        end else begin
            // Write channel handshakes; each valid drops on its own ready
            if (awvalid && awready) begin
                awvalid   <= 1'b0;
                aw_done_q <= 1'b1;
            end
            if (wvalid && wready) begin
                wvalid   <= 1'b0;
                w_done_q <= 1'b1;
            end
            if (wr_fire) begin
                wr_issued_q <= 1'b0;
                aw_done_q   <= 1'b0;
                w_done_q    <= 1'b0;
            end

            // Send side holding register
            if (ss_fire) ss_tvalid <= 1'b0;
            if (src_fire) begin
                ss_tvalid  <= 1'b1;
                ss_tdata   <= src_tdata;
                ss_tlast   <= last_sent;
                sent_cnt_q <= sent_cnt_q + pDATA_WIDTH'(1);
            end

            // Receive side output register; tlast from the FIR must match our count
            if (dst_fire) dst_tvalid <= 1'b0;
            if (sm_fire) begin
                dst_tvalid <= 1'b1;
                dst_tdata  <= sm_tdata;
                dst_tlast  <= last_recv;
                recv_cnt_q <= recv_cnt_q + pDATA_WIDTH'(1);
                if (sm_tlast != last_recv) err <= 1'b1;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        len_q      <= len;
                        sent_cnt_q <= '0;
                        recv_cnt_q <= '0;
                        coef_idx   <= '0;
                        if (len == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_q <= StTapWr;
                            done    <= 1'b0;
                            err     <= 1'b0;
                        end
                    end
                end
                StTapWr, StLenWr, StTnumWr, StStartWr: begin
                    if (!wr_issued_q) begin
                        wr_issued_q <= 1'b1;
                        awvalid     <= 1'b1;
                        wvalid      <= 1'b1;
                        awaddr      <= wr_addr;
                        wdata       <= wr_data;
                    end else if (wr_fire) begin
                        case (state_q)
                            StTapWr: begin
                                if (coef_idx == 4'(Tape_Num - 1)) begin
                                    coef_idx <= '0;
                                    state_q  <= StLenWr;
                                end else begin
                                    coef_idx <= coef_idx + 4'd1;
                                end
                            end
                            StLenWr:  state_q <= StTnumWr;
                            StTnumWr: state_q <= StStartWr;
                            default:  state_q <= StStream;
                        endcase
                    end
                end
                StStream: begin
                    if (stream_end) begin
`ifdef FIR_DRIVER_POLL_EN
                        state_q <= StPollRd;
                        arvalid <= 1'b1;
                        rready  <= 1'b1;
`else
                        state_q <= StDone;
                        done    <= 1'b1;
`endif
                    end
                end
`ifdef FIR_DRIVER_POLL_EN
                StPollRd: begin
                    if (arvalid && arready) arvalid <= 1'b0;
                    if (rvalid && rready) begin
                        if (rdata[1]) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            rready  <= 1'b0;
                        end else begin
                            // Status not ready yet: reissue immediately
                            arvalid <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_driver.sv
// Bench for fir_driver: AXI-Lite write slave with per-write ready delays, a FIR
// behavioural core on ss/sm, a sample source and a result sink checked against
// a convolution model computed from the source vector.
`timescale 1ns/1ps
module tb_fir_driver;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] len = '0;
    logic          busy, done, err;
    logic [3:0]    coef_idx;
    logic [DW-1:0] coef_data;
    logic          src_tvalid = 1'b0;
    logic [DW-1:0] src_tdata = '0;
    logic          src_tready;
    logic          dst_tvalid, dst_tlast;
    logic [DW-1:0] dst_tdata;
    logic          dst_tready = 1'b1;
    logic          awvalid, wvalid, arvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          ss_tvalid, ss_tlast;
    logic [DW-1:0] ss_tdata;
    logic          ss_tready = 1'b1;
    logic          sm_tvalid = 1'b0, sm_tlast = 1'b0;
    logic [DW-1:0] sm_tdata = '0;
    logic          sm_tready;

    fir_driver #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .len(len),
        .busy(busy), .done(done), .err(err), .coef_idx(coef_idx), .coef_data(coef_data),
        .src_tvalid(src_tvalid), .src_tdata(src_tdata), .src_tready(src_tready),
        .dst_tvalid(dst_tvalid), .dst_tdata(dst_tdata), .dst_tlast(dst_tlast),
        .dst_tready(dst_tready),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    always #5 axis_clk = ~axis_clk;

    int taps[NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    function automatic int tap_of(input logic [3:0] i);
        return (int'(i) < NT) ? taps[int'(i)] : 0;
    endfunction
    assign coef_data = DW'(tap_of(coef_idx));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Run context and logs
    int src_vec[$];
    int exp_y[$];
    int got_data[$];
    bit got_last[$];
    int aw_log[$];
    int w_log[$];
    int aw_dly[14];
    int w_dly[14];
    int cur_len = 0;
    int tlast_at = 0;
    int tl_override = -1;
    bit ss_gap = 0;
    bit dst_hold = 0;

    // Responder state
    int src_idx = 0;
    int aw_wait = 0, w_wait = 0;
    bit aw_pend = 0, w_pend = 0;
    int aw_hold = 0, w_hold = 0;
    int x_hist[$];
    int y_q[$];
    bit yl_q[$];
    int fir_in_idx = 0;
    int ar_pend = 0, rd_cnt = 0;
    int cyc = 0;
    bit seen_aw = 0, seen_ss = 0, seen_sm_stall = 0;

    // Sample everything at negedge (handshakes complete at the next posedge),
    // drive responder outputs 1ns after posedge.
    initial begin : env
        forever begin
            @(negedge axis_clk);
            cyc++;
            if (axis_rst_n) begin
                if (awvalid) seen_aw = 1;
                if (ss_tvalid) seen_ss = 1;
                if (dst_hold && dst_tvalid && !sm_tready) seen_sm_stall = 1;
                check("busy_done_exclusive", longint'(busy && done), 0);

                if (awvalid) begin
                    if (aw_pend) check("awaddr_stable", longint'(awaddr), aw_hold);
                    if (awready) begin
                        aw_log.push_back(int'(awaddr));
                        aw_pend = 0;
                        aw_wait = 0;
                    end else begin
                        aw_pend = 1;
                        aw_hold = int'(awaddr);
                        aw_wait++;
                    end
                end
                if (wvalid) begin
                    if (w_pend) check("wdata_stable", longint'($signed(wdata)), w_hold);
                    if (wready) begin
                        w_log.push_back(int'($signed(wdata)));
                        w_pend = 0;
                        w_wait = 0;
                    end else begin
                        w_pend = 1;
                        w_hold = int'($signed(wdata));
                        w_wait++;
                    end
                end

                if (src_tvalid && src_tready) src_idx++;

                if (ss_tvalid && ss_tready) begin
                    int acc;
                    check("ss_tlast", longint'(ss_tlast), longint'(fir_in_idx == cur_len - 1));
                    x_hist.push_front(int'($signed(ss_tdata)));
                    acc = 0;
                    for (int k = 0; k < NT && k < x_hist.size(); k++) acc += taps[k] * x_hist[k];
                    y_q.push_back(acc);
                    yl_q.push_back(fir_in_idx == tlast_at);
                    fir_in_idx++;
                end
                if (sm_tvalid && sm_tready && y_q.size() > 0) begin
                    void'(y_q.pop_front());
                    void'(yl_q.pop_front());
                end

                if (dst_tvalid && dst_tready) begin
                    int k;
                    k = got_data.size();
                    if (k < exp_y.size())
                        check("dst_tdata", longint'($signed(dst_tdata)), exp_y[k]);
                    else
                        check("dst_extra_result", k, exp_y.size() - 1);
                    check("dst_tlast", longint'(dst_tlast), longint'(k == cur_len - 1));
                    got_data.push_back(int'($signed(dst_tdata)));
                    got_last.push_back(dst_tlast);
                end
`ifdef FIR_DRIVER_POLL_EN
                if (arvalid && arready) begin
                    check("araddr", longint'(araddr), 0);
                    ar_pend++;
                end
                if (rvalid && rready) begin
                    ar_pend--;
                    rd_cnt++;
                end
`endif
            end

            @(posedge axis_clk);
            #1;
            awready = awvalid && (aw_wait >= ((aw_log.size() < 14) ? aw_dly[aw_log.size()] : 0));
            wready  = wvalid && (w_wait >= ((w_log.size() < 14) ? w_dly[w_log.size()] : 0));
            src_tvalid = (src_idx < src_vec.size());
            src_tdata  = (src_idx < src_vec.size()) ? DW'(src_vec[src_idx]) : '0;
            ss_tready  = !(ss_gap && (cyc % 3 == 0));
            sm_tvalid  = (y_q.size() > 0);
            sm_tdata   = (y_q.size() > 0) ? DW'(y_q[0]) : '0;
            sm_tlast   = (yl_q.size() > 0) ? yl_q[0] : 1'b0;
            dst_tready = !dst_hold;
`ifdef FIR_DRIVER_POLL_EN
            arready = arvalid;
            rvalid  = (ar_pend > 0);
            rdata   = (rd_cnt >= 2) ? DW'(6) : '0;
`endif
        end
    end

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic clear_logs();
        aw_log.delete(); w_log.delete(); got_data.delete(); got_last.delete();
        x_hist.delete(); y_q.delete(); yl_q.delete();
        src_idx = 0; fir_in_idx = 0; aw_wait = 0; w_wait = 0; aw_pend = 0; w_pend = 0;
        ar_pend = 0; rd_cnt = 0;
        seen_aw = 0; seen_ss = 0; seen_sm_stall = 0;
    endtask

    task automatic start_run(input int n);
        clear_logs();
        cur_len  = n;
        tlast_at = (tl_override >= 0) ? tl_override : n - 1;
        exp_y.delete();
        for (int i = 0; i < src_vec.size(); i++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < NT && k <= i; k++) acc += taps[k] * src_vec[i - k];
            exp_y.push_back(acc);
        end
        start = 1'b1;
        len   = DW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        check("done_reached", longint'(done), 1);
        check("busy_after_done", longint'(busy), 0);
    endtask

    task automatic check_writes();
        int ea, ed;
        check("aw_count", aw_log.size(), 14);
        check("w_count", w_log.size(), 14);
        for (int i = 0; i < 14 && i < aw_log.size() && i < w_log.size(); i++) begin
            if (i < NT) begin
                ea = 'h80 + 4 * i;
                ed = taps[i];
            end else if (i == NT) begin
                ea = 'h10;
                ed = cur_len;
            end else if (i == NT + 1) begin
                ea = 'h14;
                ed = NT;
            end else begin
                ea = 0;
                ed = 1;
            end
            check($sformatf("wr_addr[%0d]", i), aw_log[i], ea);
            check($sformatf("wr_data[%0d]", i), w_log[i], ed);
        end
    endtask

    task automatic check_results();
        check("dst_count", got_data.size(), cur_len);
`ifdef FIR_DRIVER_POLL_EN
        check("poll_reads", rd_cnt, 3);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_err"}, longint'(err), 0);
        check({tag, "_coef_idx"}, longint'(coef_idx), 0);
        check({tag, "_awvalid"}, longint'(awvalid), 0);
        check({tag, "_awaddr"}, longint'(awaddr), 0);
        check({tag, "_wvalid"}, longint'(wvalid), 0);
        check({tag, "_wdata"}, longint'(wdata), 0);
        check({tag, "_arvalid_rready"}, longint'({arvalid, rready}), 0);
        check({tag, "_ss"}, longint'({ss_tvalid, ss_tlast}), 0);
        check({tag, "_ss_tdata"}, longint'(ss_tdata), 0);
        check({tag, "_dst"}, longint'({dst_tvalid, dst_tlast}), 0);
        check({tag, "_dst_tdata"}, longint'(dst_tdata), 0);
        check({tag, "_readies"}, longint'({src_tready, sm_tready}), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c;
        for (int i = 0; i < 14; i++) begin
            aw_dly[i] = 0;
            w_dly[i]  = 0;
        end
        repeat (3) tick();
        check_all_zero("reset");
        axis_rst_n = 1'b1;
        repeat (2) tick();

        // Basic run: len 3, samples 1,2,3
        src_vec = '{1, 2, 3};
        start_run(3);
        wait_done(400);
        check_writes();
        check_results();
        check("run1_err", longint'(err), 0);
        if (got_data.size() == 3) begin
            check("run1_y0", got_data[0], 0);
            check("run1_y1", got_data[1], -10);
            check("run1_y2", got_data[2], -29);
            check("run1_last_on_y1", longint'(got_last[1]), 0);
            check("run1_last_on_y2", longint'(got_last[2]), 1);
        end

        // Uneven write readies: aw 2 cycles ahead of w, then same cycle, then w ahead
        aw_dly[0] = 0; w_dly[0] = 2;
        aw_dly[1] = 1; w_dly[1] = 1;
        for (int i = 2; i < 14; i++) begin
            aw_dly[i] = i % 2;
            w_dly[i]  = 0;
        end
        ss_gap = 1;
        src_vec = '{5, -3, 7, 100};
        start_run(4);
        wait_done(600);
        check_writes();
        check_results();
        check("run2_err", longint'(err), 0);
        ss_gap = 0;
        for (int i = 0; i < 14; i++) begin
            aw_dly[i] = 0;
            w_dly[i]  = 0;
        end

        // Downstream stall of 20 cycles mid-stream
        src_vec = '{1, 2, 3, 4, 5, 6, 7, 8};
        start_run(8);
        c = 0;
        while (got_data.size() < 2 && c < 400) begin
            tick();
            c++;
        end
        check("run3_reached_mid_stream", longint'(got_data.size() >= 2), 1);
        dst_hold = 1;
        repeat (20) tick();
        dst_hold = 0;
        wait_done(400);
        check("run3_sm_tready_dropped", longint'(seen_sm_stall), 1);
        check_results();
        check("run3_err", longint'(err), 0);

        // Zero length: immediate done with error, no transactions
        src_vec.delete();
        start_run(0);
        c = 0;
        while (!done && c < 1) begin
            tick();
            c++;
        end
        check("len0_done", longint'(done), 1);
        check("len0_err", longint'(err), 1);
        repeat (5) tick();
        check("len0_no_aw", longint'(seen_aw), 0);
        check("len0_no_ss", longint'(seen_ss), 0);
        check("len0_busy", longint'(busy), 0);

        // Early sm_tlast on result 2 of 5 (started from DONE)
        tl_override = 2;
        src_vec = '{1, 2, 3, 4, 5};
        start_run(5);
        check("run5_err_cleared_on_start", longint'(err), 0);
        wait_done(400);
        check("run5_err", longint'(err), 1);
        check_results();
        tl_override = -1;

        // Reset during tap write 5, then a fresh run from tap 0
        src_vec = '{1, 2, 3};
        start_run(3);
        c = 0;
        while (!(coef_idx == 4'd5 && awvalid) && c < 200) begin
            tick();
            c++;
        end
        check("run6_reached_tap5", longint'(coef_idx == 4'd5 && awvalid), 1);
        axis_rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        axis_rst_n = 1'b1;
        repeat (5) tick();
        check("post_reset_idle_busy", longint'(busy), 0);
        check("post_reset_idle_aw", longint'(awvalid), 0);
        start_run(3);
        wait_done(400);
        check_writes();
        check_results();
        check("run6_err", longint'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
